// File: rtl/alu_pwr_seq.sv
// alu_pwr_seq: power sequencer for the ALU domain. It drains busy work, isolates,
// then powers off; on wake it powers on, settles, then releases isolation.
// Ports: clk, rst (sync, active-high), sleep_req, wake_req, alu_busy, start_in
//        -> start_out, alu_pwr_en, iso_en, sleep_ack, wake_ack, start_drop,
//           pwr_state[2:0]
module alu_pwr_seq #(
   parameter int ISO_SETUP    = 2,
   parameter int PWRUP_DLY    = 4,
   parameter int IDLE_TIMEOUT = 0,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sleep_req,
   input  logic       wake_req,
   input  logic       alu_busy,
   input  logic       start_in,
   output logic       start_out,
   output logic       alu_pwr_en,
   output logic       iso_en,
   output logic       sleep_ack,
   output logic       wake_ack,
   output logic       start_drop,
   output logic [2:0] pwr_state
);

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_DRAIN = 3'd1,
      S_ISO   = 3'd2,
      S_OFF   = 3'd3,
      S_PWRUP = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_SETUP - 1);
   localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'(PWRUP_DLY - 1);
   localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_TIMEOUT);
   localparam int IDLE_HIT_I = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] IDLE_HIT = CNT_W'(IDLE_HIT_I);
   localparam logic AUTO = (IDLE_TIMEOUT > 0);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] dly_cnt, dly_nxt;
   logic [CNT_W-1:0] idle_cnt, idle_nxt;
   logic             idle_now;
   logic             auto_hit;
   // First non-reset edge must report the reset-entered OFF as a fresh entry.
   logic             boot_q;

   assign idle_now  = !start_in && !alu_busy;
   // idle_cnt holds idle cycles before this one; hit on the final idle cycle.
   assign auto_hit  = AUTO && idle_now && (idle_cnt >= IDLE_HIT);
   assign start_out = start_in && (state == S_RUN);
   assign pwr_state = state;

   always_comb begin
      state_nxt = state;
      dly_nxt   = dly_cnt;
      idle_nxt  = idle_cnt;
      unique case (state)
         S_RUN: begin
            if (!idle_now)
               idle_nxt = '0;
            else if (idle_cnt != IDLE_MAX)
               idle_nxt = idle_cnt + 1'b1;
            if (sleep_req || auto_hit)
               state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!alu_busy)
               state_nxt = S_ISO;
         end
         S_ISO: begin
            if (dly_cnt == ISO_LAST)
               state_nxt = S_OFF;
            else
               dly_nxt = dly_cnt + 1'b1;
         end
         S_OFF: begin
            if (wake_req)
               state_nxt = S_PWRUP;
         end
         S_PWRUP: begin
            if (dly_cnt == PU_LAST)
               state_nxt = S_RUN;
            else
               dly_nxt = dly_cnt + 1'b1;
         end
         default: state_nxt = S_OFF;
      endcase
      // Every state change starts its counters from zero.
      if (state_nxt != state) begin
         dly_nxt  = '0;
         idle_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_OFF;
         dly_cnt    <= '0;
         idle_cnt   <= '0;
         alu_pwr_en <= 1'b0;
         iso_en     <= 1'b1;
         sleep_ack  <= 1'b0;
         wake_ack   <= 1'b0;
         start_drop <= 1'b0;
         boot_q     <= 1'b1;
      end else begin
         state      <= state_nxt;
         dly_cnt    <= dly_nxt;
         idle_cnt   <= idle_nxt;
         alu_pwr_en <= (state_nxt != S_OFF);
         iso_en     <= (state_nxt == S_ISO) || (state_nxt == S_OFF) ||
                       (state_nxt == S_PWRUP);
         sleep_ack  <= (state_nxt == S_OFF) && ((state != S_OFF) || boot_q);
         wake_ack   <= (state_nxt == S_RUN) && (state != S_RUN);
         start_drop <= start_in && (state != S_RUN);
         boot_q     <= 1'b0;
      end
   end

endmodule

// File: doc/alu_pwr_seq.md
Name: alu_pwr_seq

Overview:
- Power-sequencing controller directly upstream of the ALU power domain and its AON capture logic.
- Generates the alu_pwr_en and iso_en levels consumed by the ALU and the AON capture register.
- Orders the transitions: drain busy work, then isolate, then power off; on wake, power on, settle, then release isolation.
- Gates start into the ALU so no operation is issued while the domain is not fully running.

Parameters:
- ISO_SETUP, 2, cycles iso_en is held high with power still on before alu_pwr_en drops (>=1).
- PWRUP_DLY, 4, cycles power is held on with iso_en still high before isolation releases (>=1).
- IDLE_TIMEOUT, 0, consecutive idle RUN cycles that trigger an automatic sleep; 0 disables auto-sleep.
- CNT_W, 16, width of the delay and idle counters; must hold max(ISO_SETUP, PWRUP_DLY, IDLE_TIMEOUT).

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- sleep_req  input  1  level; request power-down, sampled only in RUN.
- wake_req  input  1  level; request power-up, sampled only in OFF.
- alu_busy  input  1  ALU busy indication.
- start_in  input  1  upstream start request.
- start_out  output  1  start forwarded to the ALU.
- alu_pwr_en  output  1  ALU domain power enable.
- iso_en  output  1  isolation enable.
- sleep_ack  output  1  one-cycle pulse on entry to OFF.
- wake_ack  output  1  one-cycle pulse on entry to RUN.
- start_drop  output  1  one-cycle pulse the cycle after a start_in that was blocked.
- pwr_state  output  3  current state: RUN=0, DRAIN=1, ISO=2, OFF=3, PWRUP=4.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=OFF; alu_pwr_en=0; iso_en=1.
  - sleep_ack=0, wake_ack=0, start_drop=0; all counters cleared.
  - Applies from any state, including mid-sequence.
- Output decode (all registered except start_out):
  - alu_pwr_en=0 only in OFF.
  - iso_en=1 in ISO, OFF and PWRUP; iso_en=0 in RUN and DRAIN.
- RUN:
  - sleep_req=1, or idle_cnt reaching IDLE_TIMEOUT (when nonzero), -> DRAIN next cycle.
  - wake_req is ignored.
- DRAIN:
  - Stays while alu_busy=1; no timeout.
  - alu_busy=0 -> ISO next cycle.
- ISO:
  - Remains exactly ISO_SETUP cycles, then -> OFF.
- OFF:
  - sleep_ack=1 in the first OFF cycle, including the first OFF cycle after reset.
  - wake_req=1 -> PWRUP next cycle.
- PWRUP:
  - Remains exactly PWRUP_DLY cycles, then -> RUN.
  - wake_ack=1 in the first RUN cycle.
  - sleep_req during PWRUP is ignored; the wake sequence always completes.
- Request handling during sequences:
  - wake_req during DRAIN or ISO is ignored; the sequence reaches OFF first.
  - A still-high wake_req is then honoured on the first OFF cycle, i.e. OFF lasts one cycle.
- start gating:
  - start_out = start_in AND (state==RUN), combinational, zero latency.
  - start_in=1 in any other state is discarded and start_drop pulses on the next cycle.
  - Blocked starts are not queued.
- Idle counter:
  - Counts only in RUN, on cycles with start_in=0 and alu_busy=0.
  - Clears on any start_in or alu_busy, and on leaving RUN.
  - Saturates at IDLE_TIMEOUT.
- Simultaneous events:
  - sleep_req and start_in in the same RUN cycle: start_out=1 that cycle; state still -> DRAIN.
  - DRAIN then waits for the resulting busy to clear.

Test Plan:
- Reset/wake: assert rst 2 cycles, release, wake_req=1 for 1 cycle.
  - Expect: OFF with sleep_ack pulse on the first post-reset cycle.
  - Expect: PWRUP for exactly 4 cycles (pwr_en=1, iso_en=1), then RUN (iso_en=0) with wake_ack pulse.
- Sleep with busy: in RUN, alu_busy=1 for 3 cycles, sleep_req=1 for 1 cycle.
  - Expect: DRAIN for 3 cycles with iso_en=0.
  - Expect: ISO for 2 cycles (iso_en=1, pwr_en=1), then OFF (pwr_en=0) with sleep_ack.
- Start gating: start_in=1 in DRAIN, ISO, OFF and PWRUP.
  - Expect: start_out=0 and start_drop pulses one cycle later each time.
  - Expect: start_in=1 in RUN gives start_out=1 the same cycle.
- Auto-sleep: IDLE_TIMEOUT=5, RUN with no start and no busy.
  - Expect: DRAIN entered on the cycle after the 5th idle cycle.
  - Expect: a start_in at idle count 4 restarts the count.
- Race: wake_req held high from the first DRAIN cycle.
  - Expect: full DRAIN -> ISO(2) -> OFF for 1 cycle with sleep_ack, then PWRUP.
- Reset mid-PWRUP: assert rst on PWRUP cycle 2.
  - Expect: OFF, pwr_en=0, iso_en=1 on the next cycle, and no wake_ack.
